// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - debug-side data-memory dump reader, word reads serialized MSB-first to a byte stream
//
// Walks i_word_count consecutive data-memory words starting at i_first_addr
// (wrapping modulo 2^NB_ADDR), reading each through the memory's synchronous
// read port and sending its bytes, most significant first, over a valid/ready
// byte stream toward the debug UART transmitter.
//
// Ports:
//   clk           clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       start pulse, honoured only in IDLE
//   i_first_addr  first word address, sampled with an accepted start
//   i_word_count  number of words (0 = none), sampled with an accepted start
//   i_abort       cancel a dump in progress
//   o_rd_en       memory read strobe
//   o_rd_addr     memory read address
//   i_rd_data     memory read data, valid the cycle after o_rd_en
//   o_tx_valid    byte available
//   o_tx_data     byte to transmit
//   i_tx_ready    transmitter accepts byte
//   o_busy        high outside IDLE
//   o_done        one-cycle pulse on normal completion

module mem_dump_reader #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_first_addr,
    input  logic [NB_ADDR:0]   i_word_count,
    input  logic               i_abort,
    output logic               o_rd_en,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic               o_tx_valid,
    output logic [7:0]         o_tx_data,
    input  logic               i_tx_ready,
    output logic               o_busy,
    output logic               o_done
);

    localparam int NB_BYTES = NB_DATA / 8;
    localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
    localparam logic [NB_IDX-1:0]  LAST_IDX = NB_IDX'(NB_BYTES - 1);
    localparam logic [NB_ADDR:0]   CNT_ONE  = (NB_ADDR + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NB_ADDR-1:0]  addr;
    logic [NB_ADDR:0]    remaining;
    logic [NB_DATA-1:0]  word_buf;
    logic [NB_IDX-1:0]   byte_idx;

    logic start_ok;
    logic tx_hs;
    logic last_byte;

    assign start_ok  = (state == ST_IDLE) && i_start;
    // Valid is a pure state decode, so gating the handshake by state keeps
    // o_tx_valid independent of i_tx_ready.
    assign tx_hs     = (state == ST_SEND) && i_tx_ready;
    assign last_byte = (byte_idx == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE, while in
    // IDLE a simultaneous start takes precedence because abort is ignored there.
    always_comb begin
        state_next = state;
        if (state != ST_IDLE && i_abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state_next = (i_word_count != '0) ? ST_READ : ST_DONE;
                    end
                end
                ST_READ: state_next = ST_WAIT;
                ST_WAIT: state_next = ST_SEND;
                ST_SEND: begin
                    if (tx_hs && last_byte) begin
                        state_next = (remaining == CNT_ONE) ? ST_DONE : ST_READ;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode from registered state only
    always_comb begin
        o_rd_en    = 1'b0;
        o_tx_valid = 1'b0;
        o_done     = 1'b0;
        o_busy     = 1'b1;
        case (state)
            ST_IDLE: o_busy     = 1'b0;
            ST_READ: o_rd_en    = 1'b1;
            ST_SEND: o_tx_valid = 1'b1;
            ST_DONE: o_done     = 1'b1;
            default: ;
        endcase
    end

    // Datapath. word_buf is shifted left after every accepted byte so the
    // outgoing byte is always its top slice, straight from a register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr      <= '0;
            remaining <= '0;
            word_buf  <= '0;
            byte_idx  <= '0;
        end else begin
            if (start_ok) begin
                addr      <= i_first_addr;
                remaining <= i_word_count;
            end
            if (state == ST_WAIT) begin
                word_buf <= i_rd_data;
                byte_idx <= '0;
            end
            if (tx_hs) begin
                word_buf <= word_buf << 8;
                if (last_byte) begin
                    byte_idx  <= '0;
                    remaining <= remaining - CNT_ONE;
                    addr      <= addr + NB_ADDR'(1);
                end else begin
                    byte_idx <= byte_idx + NB_IDX'(1);
                end
            end
        end
    end

    assign o_rd_addr = addr;
    assign o_tx_data = word_buf[NB_DATA-1 -: 8];

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - directed self-checking bench for mem_dump_reader

module tb_mem_dump_reader;

    logic        clk;
    logic        i_rst_n;
    logic        i_start;
    logic [7:0]  i_first_addr;
    logic [8:0]  i_word_count;
    logic        i_abort;
    logic        o_rd_en;
    logic [7:0]  o_rd_addr;
    logic [31:0] i_rd_data;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    mem_dump_reader #(.NB_DATA(32), .NB_ADDR(8)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_first_addr (i_first_addr),
        .i_word_count (i_word_count),
        .i_abort      (i_abort),
        .o_rd_en      (o_rd_en),
        .o_rd_addr    (o_rd_addr),
        .i_rd_data    (i_rd_data),
        .o_tx_valid   (o_tx_valid),
        .o_tx_data    (o_tx_data),
        .i_tx_ready   (i_tx_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory model
    always @(posedge clk) begin
        if (o_rd_en) i_rd_data <= mem[o_rd_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int j);
        return w[31-8*j -: 8];
    endfunction

    // Ready-high dump from addr a of n words (n>=1), checked cycle by cycle.
    // inject: pulse a competing i_start mid-dump; abort_start: raise i_abort
    // together with the accepted start.
    task automatic dump_ready(input logic [7:0] a, input int n, input bit inject, input bit abort_start);
        logic [7:0]  ra;
        logic [31:0] w;
        int          k;
        int          ph;
        int          ndone;
        ndone        = 0;
        i_first_addr = a;
        i_word_count = 9'(n);
        i_start      = 1'b1;
        i_abort      = abort_start;
        i_tx_ready   = 1'b1;
        for (int cyc = 1; cyc <= n*6 + 2; cyc++) begin
            @(negedge clk);
            i_abort = 1'b0;
            i_start = inject && (cyc == 2 || cyc == 9);
            if (inject) begin
                i_first_addr = 8'h80;
                i_word_count = 9'd1;
            end
            if (o_done) ndone++;
            if (cyc <= n*6) begin
                k  = (cyc - 1) / 6;
                ph = (cyc - 1) % 6;
                ra = a + 8'(k);
                w  = mem[ra];
                if (ph == 0) begin
                    chk("rd_en", o_rd_en, 1'b1);
                    chk("rd_addr", o_rd_addr, ra);
                    chk("busy", o_busy, 1'b1);
                end else if (ph == 1) begin
                    chk("wait_rd_en", o_rd_en, 1'b0);
                    chk("wait_tx_valid", o_tx_valid, 1'b0);
                end else begin
                    chk("tx_valid", o_tx_valid, 1'b1);
                    chk("tx_data", o_tx_data, byte_of(w, ph - 2));
                end
            end else if (cyc == n*6 + 1) begin
                chk("done_pulse", o_done, 1'b1);
                chk("done_busy", o_busy, 1'b1);
            end else begin
                chk("done_low", o_done, 1'b0);
                chk("idle_busy", o_busy, 1'b0);
            end
        end
        chk("done_count", 32'(ndone), 32'd1);
        i_start = 1'b0;
    endtask

    logic [7:0] got [$];
    logic       pv;
    logic       pr;
    logic [7:0] pd;
    bit         seen_done;
    int         n_done;
    int         n_act;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5C30000 | 32'(i) | (32'(i) << 8);
        mem[8'h05] = 32'hDEADBEEF;
        mem[8'hFE] = 32'h11223344;
        mem[8'hFF] = 32'h55667788;
        mem[8'h00] = 32'h99AABBCC;
        mem[8'h10] = 32'h0123ABCD;
        mem[8'h11] = 32'hFEDC5678;

        i_rst_n = 1'b0; i_start = 1'b0; i_first_addr = '0; i_word_count = '0;
        i_abort = 1'b0; i_tx_ready = 1'b0; i_rd_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", o_rd_en, 1'b0);
        chk("rst_rd_addr", o_rd_addr, 8'h00);
        chk("rst_tx_valid", o_tx_valid, 1'b0);
        chk("rst_tx_data", o_tx_data, 8'h00);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_done", o_done, 1'b0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // Single word at 0x05: DE AD BE EF in cycles 3..6, done in 7
        dump_ready(8'h05, 1, 1'b0, 1'b0);

        // Wrap across FF -> 00
        dump_ready(8'hFE, 3, 1'b0, 1'b0);

        // Competing start ignored during a 4-word dump; abort with start in IDLE loses
        dump_ready(8'h20, 4, 1'b1, 1'b0);
        dump_ready(8'h24, 1, 1'b0, 1'b1);

        // Zero count
        i_first_addr = 8'h40; i_word_count = 9'd0; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("zero_done", o_done, 1'b1);
        chk("zero_rd_en", o_rd_en, 1'b0);
        chk("zero_tx_valid", o_tx_valid, 1'b0);
        chk("zero_busy", o_busy, 1'b1);
        @(negedge clk);
        chk("zero_done_low", o_done, 1'b0);
        chk("zero_idle", o_busy, 1'b0);
        chk("zero_rd_en2", o_rd_en, 1'b0);

        // Abort in idle has no effect
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("idle_abort_busy", o_busy, 1'b0);

        // Backpressure: 10-cycle stall over the first byte, then random ready
        got.delete();
        pv = 1'b0; pr = 1'b0; pd = '0; seen_done = 1'b0; n_done = 0;
        i_first_addr = 8'h10; i_word_count = 9'd2; i_start = 1'b1; i_tx_ready = 1'b0;
        for (int c = 1; c <= 300 && !seen_done; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (pv && !pr) begin
                chk("stall_valid", o_tx_valid, 1'b1);
                chk("stall_data", o_tx_data, pd);
            end
            if (o_done) begin
                seen_done = 1'b1;
                n_done++;
            end
            i_tx_ready = (c >= 3 && c <= 12) ? 1'b0 : 1'(($urandom_range(0, 1)));
            if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
            pv = o_tx_valid; pr = i_tx_ready; pd = o_tx_data;
        end
        chk("bp_timeout", seen_done, 1'b1);
        chk("bp_done_count", 32'(n_done), 32'd1);
        chk("bp_nbytes", 32'(got.size()), 32'd8);
        for (int j = 0; j < 8 && j < got.size(); j++)
            chk("bp_byte", got[j], byte_of(mem[8'h10 + 8'(j/4)], j % 4));
        @(negedge clk);
        chk("bp_idle", o_busy, 1'b0);
        i_tx_ready = 1'b1;

        // Abort during second word's SEND (cycle 10 = its second byte)
        i_first_addr = 8'h30; i_word_count = 9'd3; i_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        chk("pre_abort_valid", o_tx_valid, 1'b1);
        chk("pre_abort_data", o_tx_data, byte_of(mem[8'h31], 1));
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        chk("abort_valid", o_tx_valid, 1'b0);
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_done", o_done, 1'b0);
        n_act = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done || o_rd_en || o_tx_valid) n_act++;
        end
        chk("abort_quiet", 32'(n_act), 32'd0);
        dump_ready(8'h50, 2, 1'b0, 1'b0);

        // Reset during second byte of a dump from 0x00
        i_first_addr = 8'h00; i_word_count = 9'd2; i_start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            i_start = 1'b0;
        end
        chk("pre_rst_data", o_tx_data, 8'hAA);
        i_rst_n = 1'b0;
        #1;
        chk("mrst_tx_valid", o_tx_valid, 1'b0);
        chk("mrst_tx_data", o_tx_data, 8'h00);
        chk("mrst_busy", o_busy, 1'b0);
        chk("mrst_rd_addr", o_rd_addr, 8'h00);
        chk("mrst_rd_en", o_rd_en, 1'b0);
        chk("mrst_done", o_done, 1'b0);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", o_busy, 1'b0);
        dump_ready(8'h00, 1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
